// File: rtl/panel_source.sv
// Purpose: front-panel feeder; refresh clock, debounced MODE selection, tear-free lamp snapshots, lamp test.
// Latency: source to lamps up to SNAP_TICKS*2*PRESCALE cycles; lamp test to 12'hFFF in 3 cycles.
// Backpressure: none; outputs are level values that only move on REFRESHCLK falling transitions (or lamp test).
module panel_source #(
  parameter int PRESCALE   = 1024,
  parameter int DEBOUNCE   = 16,
  parameter int SNAP_TICKS = 64
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [11:0] PC,
  input  logic [11:0] AC,
  input  logic [11:0] MA,
  input  logic [11:0] MD,
  input  logic [11:0] SR,
  input  logic [11:0] STATUS,
  input  logic        BTN_MODE,
  input  logic        LAMPTEST,
  output logic        REFRESHCLK,
  output logic [11:0] GREEN,
  output logic [11:0] RED,
  output logic [11:0] YELLOW,
  output logic [1:0]  MODE
);

  localparam int PW = $clog2(PRESCALE);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int SW = (SNAP_TICKS > 1) ? $clog2(SNAP_TICKS) : 1;

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_MEM  = 2'd1,
    MODE_SW   = 2'd2
  } mode_e;

  // ---------------------------------------------------------------------------
  // Refresh timebase
  // ---------------------------------------------------------------------------
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          refresh;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  // Prescaler wraps after PRESCALE cycles; tick marks the last count.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Refresh clock is a registered toggle so the multiplexer sees a clean 50% duty clock.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      refresh <= 1'b0;
    end else if (tick) begin
      refresh <= ~refresh;
    end
  end

  assign REFRESHCLK = refresh;

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic btn_meta;
  logic btn_sync;
  logic lt_meta;
  logic lt_sync;
  logic lt_dly;
  logic lt_fall;

  // Two-flop synchronizers for the raw panel switches, plus one extra stage on
  // lamp test so its release can be detected as an edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
      lt_meta  <= 1'b0;
      lt_sync  <= 1'b0;
      lt_dly   <= 1'b0;
    end else begin
      btn_meta <= BTN_MODE;
      btn_sync <= btn_meta;
      lt_meta  <= LAMPTEST;
      lt_sync  <= lt_meta;
      lt_dly   <= lt_sync;
    end
  end

  assign lt_fall = lt_dly & ~lt_sync;

  // ---------------------------------------------------------------------------
  // Button debounce (sampled on refresh ticks only)
  // ---------------------------------------------------------------------------
  logic          deb;
  logic          deb_next;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] deb_cnt_next;
  logic          press;

  // A level change is accepted only after DEBOUNCE consecutive ticks that disagree
  // with the current debounced level; any agreeing tick restarts the count.
  always_comb begin
    deb_next     = deb;
    deb_cnt_next = deb_cnt;
    if (tick) begin
      if (btn_sync != deb) begin
        if (deb_cnt == DW'(DEBOUNCE - 1)) begin
          deb_next     = btn_sync;
          deb_cnt_next = '0;
        end else begin
          deb_cnt_next = deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt_next = '0;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      deb     <= deb_next;
      deb_cnt <= deb_cnt_next;
    end
  end

  // Only an accepted press (0 to 1) advances the mode; release is ignored.
  assign press = deb_next & ~deb;

  // ---------------------------------------------------------------------------
  // Display mode FSM
  // ---------------------------------------------------------------------------
  mode_e mode_q;
  mode_e mode_next;

  // Mode state register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_q <= MODE_RUN;
    end else begin
      mode_q <= mode_next;
    end
  end

  // Next mode: cycle RUN -> MEM -> SW -> RUN on each accepted press.
  always_comb begin
    mode_next = mode_q;
    if (press) begin
      case (mode_q)
        MODE_RUN: mode_next = MODE_MEM;
        MODE_MEM: mode_next = MODE_SW;
        default:  mode_next = MODE_RUN;
      endcase
    end
  end

  logic [11:0] sel_green;
  logic [11:0] sel_red;
  logic [11:0] sel_yellow;

  // Source mux follows the upcoming mode so a press landing on a load point
  // is displayed immediately rather than one snapshot later.
  always_comb begin
    sel_green  = PC;
    sel_red    = AC;
    sel_yellow = MD;
    case (mode_next)
      MODE_MEM: begin
        sel_green  = MA;
        sel_red    = MD;
        sel_yellow = STATUS;
      end
      MODE_SW: begin
        sel_green  = SR;
        sel_red    = AC;
        sel_yellow = STATUS;
      end
      default: begin
        sel_green  = PC;
        sel_red    = AC;
        sel_yellow = MD;
      end
    endcase
  end

  assign MODE = mode_q;

  // ---------------------------------------------------------------------------
  // Snapshot scheduling
  // ---------------------------------------------------------------------------
  logic [SW-1:0] snap_cnt;
  logic          snap_wrap;
  logic          load_pt;
  logic          load_due;
  logic          do_load;
  logic          pending;

  // Loads only happen as REFRESHCLK falls, a full half-period away from the
  // rising edge the multiplexer scans on.
  assign load_pt   = tick & refresh;
  assign snap_wrap = (snap_cnt == SW'(SNAP_TICKS - 1));
  assign load_due  = snap_wrap | pending | press | lt_fall;
  assign do_load   = load_pt & load_due & ~lt_sync;

  // Snapshot counter advances once per load point.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      snap_cnt <= '0;
    end else if (load_pt) begin
      if (snap_wrap) begin
        snap_cnt <= '0;
      end else begin
        snap_cnt <= snap_cnt + 1'b1;
      end
    end
  end

  // Pending remembers a mode change or lamp-test release until a load consumes it;
  // lamp test blocks loads, so pending survives it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pending <= 1'b0;
    end else if (do_load) begin
      pending <= 1'b0;
    end else if (press || lt_fall) begin
      pending <= 1'b1;
    end
  end

  // Lamp registers: lamp test forces all-on every cycle, otherwise hold until a due load.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      GREEN  <= '0;
      RED    <= '0;
      YELLOW <= '0;
    end else if (lt_sync) begin
      GREEN  <= 12'hFFF;
      RED    <= 12'hFFF;
      YELLOW <= 12'hFFF;
    end else if (do_load) begin
      GREEN  <= sel_green;
      RED    <= sel_red;
      YELLOW <= sel_yellow;
    end
  end

endmodule

// File: tb/tb_panel_source.sv
// Purpose: scoreboard bench for panel_source with PRESCALE=4, DEBOUNCE=3, SNAP_TICKS=2.
// Latency: expected lamp/mode changes are queued by stimulus and popped by a monitor on every observed change.
// Backpressure: none; the monitor samples on falling CLK edges.
module tb_panel_source;

  logic        CLK;
  logic        RESET_N;
  logic [11:0] PC, AC, MA, MD, SR, STATUS;
  logic        BTN_MODE, LAMPTEST;
  logic        REFRESHCLK;
  logic [11:0] GREEN, RED, YELLOW;
  logic [1:0]  MODE;

  panel_source #(.PRESCALE(4), .DEBOUNCE(3), .SNAP_TICKS(2)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .PC(PC), .AC(AC), .MA(MA), .MD(MD), .SR(SR), .STATUS(STATUS),
    .BTN_MODE(BTN_MODE), .LAMPTEST(LAMPTEST),
    .REFRESHCLK(REFRESHCLK), .GREEN(GREEN), .RED(RED), .YELLOW(YELLOW), .MODE(MODE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] exp_out_q[$];
  logic [1:0]  exp_mode_q[$];
  logic        mon_en = 1'b0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %09h, expected %09h", name, act, exp);
    end
  endtask

  // Monitor: every change of lamps or mode must match the next queued expectation.
  logic [35:0] last_out = '0;
  logic [1:0]  last_mode = '0;
  logic        last_rclk = 1'b0;
  always @(negedge CLK) begin
    logic [35:0] cur;
    logic [35:0] e;
    cur = {GREEN, RED, YELLOW};
    if (mon_en) begin
      if (cur !== last_out) begin
        if (exp_out_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_out: got %09h, expected no change", cur);
        end else begin
          e = exp_out_q.pop_front();
          check("out_value", cur, e);
        end
        // Snapshots (not lamp test) must land as REFRESHCLK falls.
        if (cur !== 36'hFFF_FFF_FFF)
          check("load_align", {34'd0, last_rclk, REFRESHCLK}, 36'd2);
      end
      if (MODE !== last_mode) begin
        if (exp_mode_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_mode: got %0d, expected no change", MODE);
        end else begin
          check("mode_value", {34'd0, MODE}, {34'd0, exp_mode_q.pop_front()});
        end
      end
    end
    last_out  = cur;
    last_mode = MODE;
    last_rclk = REFRESHCLK;
  end

  task automatic count_until(input logic lvl, output int n);
    n = 0;
    while (REFRESHCLK !== lvl && n < 40) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic press(input int high_cycles);
    BTN_MODE = 1'b1;
    repeat (high_cycles) @(negedge CLK);
    BTN_MODE = 1'b0;
    repeat (24) @(negedge CLK);
  endtask

  localparam logic [35:0] OUT_M0_A = {12'o1234, 12'o7777, 12'o0001};
  localparam logic [35:0] OUT_M0_B = {12'o4321, 12'o7777, 12'o0001};
  localparam logic [35:0] OUT_M1   = {12'o0400, 12'o0001, 12'o0003};
  localparam logic [35:0] OUT_M2   = {12'o5252, 12'o7777, 12'o0003};
  localparam logic [35:0] OUT_LAMP = {12'hFFF, 12'hFFF, 12'hFFF};

  initial begin
    int  n;
    logic lv;
    RESET_N  = 1'b0;
    PC = 12'o1234; AC = 12'o7777; MA = 12'o0400;
    MD = 12'o0001; SR = 12'o5252; STATUS = 12'o0003;
    BTN_MODE = 1'b0;
    LAMPTEST = 1'b0;

    // Reset state with nonzero sources.
    repeat (3) @(negedge CLK);
    check("reset_lamps", {GREEN, RED, YELLOW}, 36'd0);
    check("reset_rclk_mode", {33'd0, REFRESHCLK, MODE}, 36'd0);

    mon_en = 1'b1;
    exp_out_q.push_back(OUT_M0_A);
    RESET_N = 1'b1;

    // Refresh clock timing: first rise 4 cycles after release, then 4-cycle halves.
    count_until(1'b1, n);
    check("rclk_first_rise", n, 4);
    count_until(1'b0, n);
    check("rclk_high_half", n, 4);
    count_until(1'b1, n);
    check("rclk_low_half", n, 4);

    // First snapshot lands at the second load point; later PC change waits for next due load.
    repeat (8) @(negedge CLK);
    check("first_snapshot_green", {24'd0, GREEN}, {24'd0, 12'o1234});
    PC = 12'o4321;
    exp_out_q.push_back(OUT_M0_B);
    repeat (8) @(negedge CLK);
    check("green_held_between_loads", {24'd0, GREEN}, {24'd0, 12'o1234});
    repeat (12) @(negedge CLK);

    // Two-tick glitch aligned just after a tick: no mode change.
    lv = REFRESHCLK;
    n = 0;
    while (REFRESHCLK === lv && n < 20) begin @(negedge CLK); n++; end
    BTN_MODE = 1'b1;
    repeat (8) @(negedge CLK);
    BTN_MODE = 1'b0;
    repeat (20) @(negedge CLK);
    check("glitch_mode", {34'd0, MODE}, 36'd0);

    // Three clean presses: 0 -> 1 -> 2 -> 0, each forcing a reload.
    exp_mode_q.push_back(2'd1); exp_out_q.push_back(OUT_M1);
    press(16);
    exp_mode_q.push_back(2'd2); exp_out_q.push_back(OUT_M2);
    press(16);
    exp_mode_q.push_back(2'd0); exp_out_q.push_back(OUT_M0_B);
    press(16);
    check("mode_after_three", {34'd0, MODE}, 36'd0);

    // Long hold: single increment.
    exp_mode_q.push_back(2'd1); exp_out_q.push_back(OUT_M1);
    press(60);
    check("mode_after_hold", {34'd0, MODE}, 36'd1);

    // Lamp test: all-on within 3 cycles; mode still advances underneath.
    exp_out_q.push_back(OUT_LAMP);
    LAMPTEST = 1'b1;
    repeat (3) @(negedge CLK);
    check("lamp_all_on", {GREEN, RED, YELLOW}, OUT_LAMP);
    exp_mode_q.push_back(2'd2);
    press(16);
    check("lamp_held_after_press", {GREEN, RED, YELLOW}, OUT_LAMP);
    exp_out_q.push_back(OUT_M2);
    LAMPTEST = 1'b0;
    repeat (30) @(negedge CLK);
    check("after_lamp_out", {GREEN, RED, YELLOW}, OUT_M2);

    // Asynchronous reset mid-scan with MODE=2 and REFRESHCLK high.
    n = 0;
    while (REFRESHCLK !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    check("pre_reset_state", {33'd0, REFRESHCLK, MODE}, {33'd0, 1'b1, 2'd2});
    mon_en = 1'b0;
    #1 RESET_N = 1'b0;
    #1;
    check("async_reset_lamps", {GREEN, RED, YELLOW}, 36'd0);
    check("async_reset_rclk_mode", {33'd0, REFRESHCLK, MODE}, 36'd0);

    check("out_queue_drained", exp_out_q.size(), 36'd0);
    check("mode_queue_drained", exp_mode_q.size(), 36'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/panel_source.md
Name: panel_source

Overview:
- Upstream feeder for the front-panel LED multiplexer.
- Generates the panel refresh clock and selects which CPU registers drive the green, red and yellow 12-bit lamp groups.
- Takes tear-free snapshots of those registers so values never change while the multiplexer is mid-scan.
- Debounces the panel MODE push-button and supports a lamp-test override.

Parameters:
- PRESCALE, 1024, CLK cycles per refresh tick (≥2).
- DEBOUNCE, 16, consecutive refresh ticks of stable button level needed to accept a change (≥1).
- SNAP_TICKS, 64, refresh-clock periods between periodic snapshots (≥1).

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- PC  in  12  program counter
- AC  in  12  accumulator
- MA  in  12  memory address
- MD  in  12  memory data
- SR  in  12  switch register
- STATUS  in  12  packed status lamps (link, run, IR, etc.)
- BTN_MODE  in  1  raw asynchronous mode push-button, high = pressed
- LAMPTEST  in  1  raw asynchronous lamp-test switch, high = test
- REFRESHCLK  out  1  registered refresh clock to the multiplexer, 50% duty
- GREEN  out  12  green group value
- RED  out  12  red group value
- YELLOW  out  12  yellow group value
- MODE  out  2  current display mode, 0..2

Behaviour:
- Reset is asynchronous and active-low. While RESET_N is low:
  - prescaler = 0, REFRESHCLK = 0, MODE = 0.
  - GREEN, RED and YELLOW = 0.
  - Sync flops = 0, debounced button = 0, debounce count = 0, snapshot count = 0.
- Reset release mid-operation: normal counting starts on the first CLK edge after release. No tick is issued on that cycle.
- Prescaler counts 0..PRESCALE-1. TICK is asserted for one cycle when the count equals PRESCALE-1; the count then wraps to 0.
- REFRESHCLK toggles on each TICK, giving a period of 2*PRESCALE CLK cycles.
- BTN_MODE and LAMPTEST each pass through a 2-flop synchronizer before any use.
- Debounce is sampled on TICK only:
  - If the synced button ≠ the debounced level, increment the count. Otherwise clear it.
  - When the count reaches DEBOUNCE, the debounced level takes the synced value and the count clears.
  - A shorter glitch leaves no effect.
- MODE advances 0→1→2→0 exactly once per debounced 0→1 transition. A held button never repeats. Release has no effect.
- Source selection by MODE:
  - 0: GREEN=PC, RED=AC, YELLOW=MD.
  - 1: GREEN=MA, RED=MD, YELLOW=STATUS.
  - 2: GREEN=SR, RED=AC, YELLOW=STATUS.
- Load point: a TICK on which REFRESHCLK is currently 1, i.e. on its falling transition. Outputs therefore never change in the cycle before a REFRESHCLK rising edge.
- Snapshot counter counts load points modulo SNAP_TICKS. A load is "due" at wrap, or when a pending flag is set.
- The pending flag is set by:
  - a MODE change;
  - the synced LAMPTEST falling.
- On a load point with a load due, GREEN/RED/YELLOW register the selected sources and the pending flag clears.
- Simultaneous MODE change and a load point: the load uses the new MODE if it updated that same cycle, else the pending flag carries it to the next load point.
- Lamp test: while synced LAMPTEST = 1, GREEN/RED/YELLOW = 12'hFFF, loaded on the next CLK edge regardless of load point. MODE still advances on button presses.
- After LAMPTEST drops, outputs hold 12'hFFF until the next load point, which is forced by the pending flag.
- Latency:
  - Source change to output: up to SNAP_TICKS*2*PRESCALE cycles.
  - Debounced press to displayed new mode: at most one REFRESHCLK period.

Test Plan:
- Reset with PRESCALE=4: hold RESET_N=0 with inputs nonzero -> all outputs 0. Release -> REFRESHCLK first rises 4 CLK after release, then toggles every 4 CLK.
- Snapshot with SNAP_TICKS=2: PC=12'o1234, AC=12'o7777, MD=12'o0001 in MODE 0 -> GREEN=12'o1234, RED=12'o7777, YELLOW=12'o0001 at the second load point. A PC change between load points leaves GREEN unchanged until the next due load, which then loads the new PC. No output change is ever coincident with a REFRESHCLK rise.
- Debounce with DEBOUNCE=3: a 2-tick button pulse -> MODE stays 0. A 3-tick-stable press -> MODE=1. Three clean presses from 0 -> 1, 2, 0. A long hold -> a single increment.
- Mode change forces reload: in MODE 1 with MA=12'o0400, STATUS=12'o0003, press -> next load point shows GREEN=SR, RED=AC, YELLOW=12'o0003 without waiting for SNAP_TICKS.
- Lamp test: assert LAMPTEST -> all outputs 12'hFFF within 3 CLK. Deassert -> outputs return to selected sources at the next load point.
- Async reset mid-scan: assert RESET_N low between ticks with MODE=2 and REFRESHCLK=1 -> REFRESHCLK, MODE and outputs all clear immediately, without waiting for a CLK edge.
